// File: rtl/move_sequencer.sv
// Column-button move sequencer for a 4-column drop game: debounces a single press,
// refuses full columns, issues a one-cycle move strobe and auto-moves on turn timeout.
module move_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int TURN_TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn_n,
    input  logic [15:0] gameboard,
    input  logic [1:0]  game_status,
    output logic        move_enable,
    output logic [3:0]  move_column,
    output logic        reject,
    output logic        timeout,
    output logic        busy,
    output logic [4:0]  move_count,
    output logic [2:0]  seq_state
);

    localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STL_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = $clog2(TURN_TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_CHECK    = 3'd2,
        S_ISSUE    = 3'd3,
        S_SETTLE   = 3'd4,
        S_WAIT_REL = 3'd5,
        S_OVER     = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [DBC_W-1:0]   dbc_q, dbc_d;
    logic [STL_W-1:0]   stl_q, stl_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               move_enable_q, move_enable_d;
    logic [3:0]         move_column_q, move_column_d;
    logic               reject_q, reject_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic [4:0]         move_count_q, move_count_d;

    logic [3:0] full_cols;
    logic       free_any;
    logic [1:0] free_col;
    logic       timer_hit;
    logic       press;
    logic       unused_board;

    // Only the top row tells us whether a column can still take a piece.
    assign full_cols    = gameboard[15:12];
    assign unused_board = ^gameboard[11:0];

    function automatic logic one_low(input logic [3:0] b);
        logic [3:0] inv;
        inv = ~b;
        return (inv != 4'd0) && ((inv & (inv - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] b);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!b[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] col_pattern(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] n);
        return (n >= 5'd16) ? 5'd16 : n + 5'd1;
    endfunction

    assign press     = one_low(btn_n);
    assign free_any  = (full_cols != 4'b1111);
    assign free_col  = low_index(full_cols);
    assign timer_hit = (TURN_TIMEOUT != 0) && (int'(tmr_q) >= TURN_TIMEOUT - 1);

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        dbc_d         = dbc_q;
        stl_d         = stl_q;
        tmr_d         = tmr_q;
        move_enable_d = 1'b0;
        move_column_d = move_column_q;
        reject_d      = 1'b0;
        timeout_d     = 1'b0;
        move_count_d  = move_count_q;

        if (game_status != 2'b00 || state_q == S_OVER) begin
            state_d       = S_OVER;
            move_column_d = 4'b1111;
        end else begin
            case (state_q)
                S_IDLE, S_DEBOUNCE: begin
                    if (timer_hit && free_any) begin
                        // Auto-move preempts any debounce in progress.
                        timeout_d = 1'b1;
                        state_d   = S_ISSUE;
                        col_d     = free_col;
                        dbc_d     = '0;
                        tmr_d     = '0;
                    end else begin
                        if (timer_hit) begin
                            tmr_d = TMR_W'(TURN_TIMEOUT);
                        end else if (TURN_TIMEOUT != 0) begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                        if (state_q == S_IDLE) begin
                            if (press) begin
                                col_d   = low_index(btn_n);
                                dbc_d   = DBC_W'(1);
                                state_d = (DEBOUNCE_CYCLES <= 1) ? S_CHECK : S_DEBOUNCE;
                            end
                        end else if (btn_n == col_pattern(col_q)) begin
                            dbc_d = dbc_q + DBC_W'(1);
                            if (int'(dbc_q) + 1 >= DEBOUNCE_CYCLES) begin
                                state_d = S_CHECK;
                            end
                        end else begin
                            dbc_d   = '0;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_CHECK: begin
                    dbc_d = '0;
                    if (full_cols[col_q]) begin
                        reject_d = 1'b1;
                        state_d  = S_WAIT_REL;
                    end else begin
                        move_enable_d = 1'b1;
                        move_column_d = col_pattern(col_q);
                        move_count_d  = sat_inc(move_count_q);
                        tmr_d         = '0;
                        state_d       = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmr_d = '0;
                    // Arriving from a timeout the strobe has not fired yet.
                    if (!move_enable_q) begin
                        move_enable_d = 1'b1;
                        move_column_d = col_pattern(col_q);
                        move_count_d  = sat_inc(move_count_q);
                    end else begin
                        stl_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (int'(stl_q) >= SETTLE_CYCLES - 1) begin
                        stl_d         = '0;
                        move_column_d = 4'b1111;
                        state_d       = S_WAIT_REL;
                    end else begin
                        stl_d = stl_q + STL_W'(1);
                    end
                end
                S_WAIT_REL: begin
                    if (btn_n == 4'b1111) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            dbc_q         <= '0;
            stl_q         <= '0;
            tmr_q         <= '0;
            move_enable_q <= 1'b0;
            move_column_q <= 4'b1111;
            reject_q      <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            move_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            dbc_q         <= dbc_d;
            stl_q         <= stl_d;
            tmr_q         <= tmr_d;
            move_enable_q <= move_enable_d;
            move_column_q <= move_column_d;
            reject_q      <= reject_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
            move_count_q  <= move_count_d;
        end
    end

    assign move_enable = move_enable_q;
    assign move_column = move_column_q;
    assign reject      = reject_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;
    assign move_count  = move_count_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2, TURN_TIMEOUT=20.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn_n;
    logic [15:0] gameboard;
    logic [1:0]  game_status;
    logic        move_enable;
    logic [3:0]  move_column;
    logic        reject;
    logic        timeout;
    logic        busy;
    logic [4:0]  move_count;
    logic [2:0]  seq_state;

    int vectors = 0;
    int errors  = 0;

    move_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (2),
        .TURN_TIMEOUT   (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .gameboard  (gameboard),
        .game_status(game_status),
        .move_enable(move_enable),
        .move_column(move_column),
        .reject     (reject),
        .timeout    (timeout),
        .busy       (busy),
        .move_count (move_count),
        .seq_state  (seq_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; btn_n = 4'b1111; gameboard = 16'h0000; game_status = 2'b00;
        tick(); tick();
        check("rst_state", 16'(seq_state), 16'd0);
        check("rst_me", 16'(move_enable), 16'd0);
        check("rst_col", 16'(move_column), 16'hF);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_cnt", 16'(move_count), 16'd0);
        check("rst_rej", 16'(reject), 16'd0);
        check("rst_to", 16'(timeout), 16'd0);

        // Normal move on column 0
        reset = 1'b0; btn_n = 4'b1110;
        tick();
        check("n_e0_state", 16'(seq_state), 16'd1);
        check("n_e0_busy", 16'(busy), 16'd1);
        tick(); tick();
        check("n_e2_state", 16'(seq_state), 16'd1);
        check("n_e2_me", 16'(move_enable), 16'd0);
        tick();
        check("n_e3_state", 16'(seq_state), 16'd2);
        tick();
        check("n_e4_state", 16'(seq_state), 16'd3);
        check("n_e4_me", 16'(move_enable), 16'd1);
        check("n_e4_col", 16'(move_column), 16'hE);
        check("n_e4_cnt", 16'(move_count), 16'd1);
        tick();
        check("n_e5_state", 16'(seq_state), 16'd4);
        check("n_e5_me", 16'(move_enable), 16'd0);
        check("n_e5_col", 16'(move_column), 16'hE);
        tick();
        check("n_e6_col", 16'(move_column), 16'hE);
        tick();
        check("n_e7_state", 16'(seq_state), 16'd5);
        check("n_e7_col", 16'(move_column), 16'hF);
        tick(); tick();
        check("n_hold_state", 16'(seq_state), 16'd5);
        check("n_hold_me", 16'(move_enable), 16'd0);
        check("n_hold_cnt", 16'(move_count), 16'd1);
        btn_n = 4'b1111;
        tick();
        check("n_rel_state", 16'(seq_state), 16'd0);
        check("n_rel_busy", 16'(busy), 16'd0);

        // Glitch and two-button press
        btn_n = 4'b1101;
        tick(); tick();
        btn_n = 4'b1111;
        tick();
        check("g_state", 16'(seq_state), 16'd0);
        check("g_me", 16'(move_enable), 16'd0);
        btn_n = 4'b1001;
        tick(); tick(); tick();
        check("dbl_state", 16'(seq_state), 16'd0);
        check("dbl_cnt", 16'(move_count), 16'd1);

        // Full column 3
        gameboard = 16'h8000; btn_n = 4'b0111;
        tick(); tick(); tick(); tick();
        check("f_e3_state", 16'(seq_state), 16'd2);
        tick();
        check("f_e4_rej", 16'(reject), 16'd1);
        check("f_e4_me", 16'(move_enable), 16'd0);
        check("f_e4_state", 16'(seq_state), 16'd5);
        tick();
        check("f_e5_rej", 16'(reject), 16'd0);
        tick();
        check("f_hold_state", 16'(seq_state), 16'd5);
        check("f_cnt", 16'(move_count), 16'd1);
        btn_n = 4'b1111;
        tick();
        check("f_rel_state", 16'(seq_state), 16'd0);

        // Reset clears move count; then turn timeout with column 0 full
        reset = 1'b1;
        tick();
        check("r2_cnt", 16'(move_count), 16'd0);
        reset = 1'b0; gameboard = 16'h1000;
        repeat (19) tick();
        check("t19_to", 16'(timeout), 16'd0);
        check("t19_state", 16'(seq_state), 16'd0);
        tick();
        check("t20_to", 16'(timeout), 16'd1);
        check("t20_me", 16'(move_enable), 16'd0);
        check("t20_state", 16'(seq_state), 16'd3);
        tick();
        check("t21_me", 16'(move_enable), 16'd1);
        check("t21_to", 16'(timeout), 16'd0);
        check("t21_col", 16'(move_column), 16'hD);
        check("t21_cnt", 16'(move_count), 16'd1);
        tick();
        check("t22_state", 16'(seq_state), 16'd4);

        // Game over mid-SETTLE
        game_status = 2'b01;
        tick();
        check("o_state", 16'(seq_state), 16'd6);
        check("o_col", 16'(move_column), 16'hF);
        btn_n = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("o_me", 16'(move_enable), 16'd0);
            check("o_rej", 16'(reject), 16'd0);
            check("o_to", 16'(timeout), 16'd0);
        end
        game_status = 2'b00;
        tick();
        check("o_hold_state", 16'(seq_state), 16'd6);
        check("o_cnt", 16'(move_count), 16'd1);
        reset = 1'b1;
        tick();
        check("o_rst_state", 16'(seq_state), 16'd0);
        check("o_rst_cnt", 16'(move_count), 16'd0);
        check("o_rst_col", 16'(move_column), 16'hF);

        // Timer expiry with every column full: no move
        reset = 1'b0; btn_n = 4'b1111; gameboard = 16'hF000;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("nf_to", 16'(timeout), 16'd0);
            check("nf_me", 16'(move_enable), 16'd0);
        end

        // Reset during ISSUE
        reset = 1'b1;
        tick();
        reset = 1'b0; gameboard = 16'h0000; btn_n = 4'b1011;
        tick(); tick(); tick(); tick(); tick();
        check("ri_me", 16'(move_enable), 16'd1);
        check("ri_col", 16'(move_column), 16'hB);
        reset = 1'b1;
        tick();
        check("ri_rst_me", 16'(move_enable), 16'd0);
        check("ri_rst_cnt", 16'(move_count), 16'd0);
        check("ri_rst_state", 16'(seq_state), 16'd0);
        check("ri_rst_col", 16'(move_column), 16'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
